// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t : frame receiver FSM states
//   PAR_EVEN / PAR_ODD : target XOR of data plus parity bit for each mode
//   cnt_width() : width of a counter that must hold values 0 .. max_count-1
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Never returns less than one bit so tiny counts still get a real register.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages reset to the line's idle level so no false edge is seen
  // downstream when reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// Oversampled UART frame receiver: start detect, mid-bit sampling LSB-first,
// optional parity, one or two stop bits, and line-break detection.
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   tick           - one-clk oversample strobe at OVERSAMPLE x baud
//   rx_in          - raw asynchronous serial line, idle high
//   data_out       - received word, forced to zero on any stop error
//   data_valid     - one-cycle pulse at the end of every completed frame
//   stop_bit_error - at least one stop sample was low
//   parity_error   - parity mismatch (always 0 without parity)
//   break_detect   - data, parity and stop samples were all low
//   busy           - receiver is anywhere but IDLE
// ---------------------------------------------------------------------------
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 stop_bit_error,
  output logic                 parity_error,
  output logic                 break_detect,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_TARGET = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam bit               HAS_PARITY = (PARITY_EN != 0);

  rx_state_t            state, state_next;
  logic                 rxs, rxs_prev;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 stop_low_seen;
  logic                 stop_high_seen;

  logic start_edge, half_point, full_point, frame_done;
  logic stop_err_final, brk_final, par_err_final;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rxs)
  );

  // The final stop sample is the current rxs, so the end-of-frame results
  // fold it in combinationally and get registered on that same edge.
  assign start_edge     = rxs_prev && !rxs;
  assign half_point     = tick && (tick_cnt == HALF_LAST);
  assign full_point     = tick && (tick_cnt == FULL_LAST);
  assign frame_done     = (state == STOP) && full_point && (bit_cnt == STOP_LAST);
  assign stop_err_final = stop_low_seen || !rxs;
  assign brk_final      = (shift_reg == '0) && (!HAS_PARITY || !par_bit) &&
                          !stop_high_seen && !rxs;
  assign par_err_final  = HAS_PARITY && ((^shift_reg ^ par_bit) != PAR_TARGET);
  assign busy           = (state != IDLE);

  // State register only; all transition decisions live in the block below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Leaving STOP goes straight to IDLE on the edge that
  // registers the outputs, so a start edge right after data_valid is caught.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_edge) state_next = START;
      START:    if (half_point) state_next = rxs ? IDLE : DATA;
      DATA:     if (full_point && (bit_cnt == DATA_LAST))
                  state_next = HAS_PARITY ? PARITY : STOP;
      PARITY:   if (full_point) state_next = STOP;
      STOP:     if (frame_done) state_next = brk_final ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rxs) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: tick counter, bit counter, shift register, stop/parity
  // accumulators and the registered frame results. Counters move only on
  // tick; the edge-detect history is refreshed every clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxs_prev       <= 1'b1;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      par_bit        <= 1'b0;
      stop_low_seen  <= 1'b0;
      stop_high_seen <= 1'b0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      stop_bit_error <= 1'b0;
      parity_error   <= 1'b0;
      break_detect   <= 1'b0;
    end else begin
      rxs_prev   <= rxs;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            par_bit        <= 1'b0;
            stop_low_seen  <= 1'b0;
            stop_high_seen <= 1'b0;
          end
        end
        START: begin
          if (tick) tick_cnt <= half_point ? '0 : tick_cnt + CNT_W'(1);
        end
        DATA: begin
          if (tick) tick_cnt <= full_point ? '0 : tick_cnt + CNT_W'(1);
          if (full_point) begin
            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        PARITY: begin
          if (tick) tick_cnt <= full_point ? '0 : tick_cnt + CNT_W'(1);
          if (full_point) par_bit <= rxs;
        end
        STOP: begin
          if (tick) tick_cnt <= full_point ? '0 : tick_cnt + CNT_W'(1);
          if (full_point) begin
            bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + BIT_W'(1);
            if (rxs) stop_high_seen <= 1'b1;
            else     stop_low_seen  <= 1'b1;
          end
        end
        default: begin
          tick_cnt <= '0;
        end
      endcase
      if (frame_done) begin
        data_valid     <= 1'b1;
        stop_bit_error <= stop_err_final;
        parity_error   <= par_err_final;
        break_detect   <= brk_final;
        data_out       <= stop_err_final ? '0 : shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Drives three receiver configurations (8N1, 8E1, 7N2) with directed and
// random frames; a frame-level model predicts every data_valid result.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic rx_a, rx_b, rx_c;

  logic [7:0] dout_a, dout_b;
  logic [6:0] dout_c;
  logic dv_a, serr_a, perr_a, brk_a, busy_a;
  logic dv_b, serr_b, perr_b, brk_b, busy_b;
  logic dv_c, serr_c, perr_c, brk_c, busy_c;

  int checks   = 0;
  int failures = 0;
  int tick_div = 1;
  int dv_double = 0;
  logic [2:0] dv_prev = 3'b000;

  // Per-configuration frame format, indexed 0 = A, 1 = B, 2 = C.
  int   nbits [3] = '{8, 8, 7};
  bit   haspar[3] = '{1'b0, 1'b1, 1'b0};
  bit   parodd[3] = '{1'b0, 1'b0, 1'b0};
  int   nstop [3] = '{1, 1, 2};

  // Entries are {dut index[1:0], break, parity err, stop err, data[8:0]}.
  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];

  uart_rx_frame dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rx_a),
    .data_out(dout_a), .data_valid(dv_a), .stop_bit_error(serr_a),
    .parity_error(perr_a), .break_detect(brk_a), .busy(busy_a)
  );

  uart_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rx_b),
    .data_out(dout_b), .data_valid(dv_b), .stop_bit_error(serr_b),
    .parity_error(perr_b), .break_detect(brk_b), .busy(busy_b)
  );

  uart_rx_frame #(.DATA_BITS(7), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rx_c),
    .data_out(dout_c), .data_valid(dv_c), .stop_bit_error(serr_c),
    .parity_error(perr_c), .break_detect(brk_c), .busy(busy_c)
  );

  always #5 clk = ~clk;

  // Oversample strobe: one tick every tick_div clocks, changed on negedge.
  initial begin
    int divcnt;
    divcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (divcnt == 0);
      divcnt = (divcnt + 1 >= tick_div) ? 0 : divcnt + 1;
    end
  end

  // Capture every data_valid pulse and watch for back-to-back pulses.
  always @(negedge clk) begin
    if (dv_a) obs_q.push_back({2'd0, brk_a, perr_a, serr_a, 1'b0, dout_a});
    if (dv_b) obs_q.push_back({2'd1, brk_b, perr_b, serr_b, 1'b0, dout_b});
    if (dv_c) obs_q.push_back({2'd2, brk_c, perr_c, serr_c, 2'b00, dout_c});
    if ((dv_a && dv_prev[0]) || (dv_b && dv_prev[1]) || (dv_c && dv_prev[2]))
      dv_double = dv_double + 1;
    dv_prev = {dv_c, dv_b, dv_a};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: what the receiver must report for a given frame.
  function automatic logic [11:0] expectRecord(input int which,
      input logic [8:0] data, input logic par_bit, input logic [1:0] stops);
    logic [8:0] d;
    logic serr, all_low, perr, brk;
    d = data & 9'((1 << nbits[which]) - 1);
    serr = 1'b0;
    all_low = 1'b1;
    for (int i = 0; i < nstop[which]; i++) begin
      if (stops[i] == 1'b0) serr = 1'b1;
      else all_low = 1'b0;
    end
    perr = haspar[which] &&
           ((($countones(d) + int'(par_bit)) % 2) != int'(parodd[which]));
    brk  = (d == 9'd0) && (!haspar[which] || !par_bit) && all_low;
    return {brk, perr, serr, serr ? 9'd0 : d};
  endfunction

  function automatic logic [11:0] currentRec(input int which);
    case (which)
      0:       return {brk_a, perr_a, serr_a, 1'b0, dout_a};
      1:       return {brk_b, perr_b, serr_b, 1'b0, dout_b};
      default: return {brk_c, perr_c, serr_c, 2'b00, dout_c};
    endcase
  endfunction

  function automatic logic currentBusy(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic setLine(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic holdBits(input int nbit);
    repeat (nbit * OS * tick_div) @(negedge clk);
  endtask

  // Send one complete frame on a line and record the predicted result.
  // A trailing low stop bit is followed by one idle bit so the next start
  // edge is visible.
  task automatic applyStimulus(input int which, input logic [8:0] data,
                               input logic par_bit, input logic [1:0] stops);
    setLine(which, 1'b0);
    holdBits(1);
    for (int i = 0; i < nbits[which]; i++) begin
      setLine(which, data[i]);
      holdBits(1);
    end
    if (haspar[which]) begin
      setLine(which, par_bit);
      holdBits(1);
    end
    for (int i = 0; i < nstop[which]; i++) begin
      setLine(which, stops[i]);
      holdBits(1);
    end
    exp_q.push_back({2'(which), expectRecord(which, data, par_bit, stops)});
    if (stops[nstop[which]-1] == 1'b0) begin
      setLine(which, 1'b1);
      holdBits(1);
    end
  endtask

  // Compare captured pulses against predictions, then check the outputs
  // still hold the last result and the receiver has gone idle.
  task automatic drain(input string tag);
    int n;
    logic [13:0] last;
    repeat (8) @(negedge clk);
    checkOutput({tag, " count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput(tag, obs_q[i], exp_q[i]);
    if (exp_q.size() > 0) begin
      last = exp_q[exp_q.size()-1];
      checkOutput({tag, " hold"}, {last[13:12], currentRec(int'(last[13:12]))}, last);
      checkOutput({tag, " busy"}, currentBusy(int'(last[13:12])), 0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic randomFrames(input int which, input int count, input string tag);
    logic [8:0] data;
    logic par;
    logic [1:0] stops;
    for (int k = 0; k < count; k++) begin
      data  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) data = 9'd0;
      par   = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      applyStimulus(which, data, par, stops);
    end
    drain(tag);
  endtask

  initial begin
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checkOutput("reset outputs", currentRec(w), 0);
      checkOutput("reset busy", currentBusy(w), 0);
    end
    checkOutput("reset dv", {dv_c, dv_b, dv_a}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] directed frames");
    applyStimulus(0, 9'h0A5, 1'b0, 2'b11);
    drain("good A5");
    applyStimulus(0, 9'h03C, 1'b0, 2'b10);
    drain("stop low 3C");
    applyStimulus(1, 9'h007, 1'b0, 2'b11);
    drain("parity bad 07");
    applyStimulus(1, 9'h007, 1'b1, 2'b11);
    drain("parity good 07");

    $display("[TB] start glitch");
    setLine(0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("glitch busy rise", busy_a, 1);
    setLine(0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("glitch busy fall", busy_a, 0);
    drain("glitch");

    $display("[TB] line break");
    setLine(0, 1'b0);
    holdBits(20);
    checkOutput("break busy held", busy_a, 1);
    exp_q.push_back({2'd0, expectRecord(0, 9'd0, 1'b0, 2'b00)});
    setLine(0, 1'b1);
    holdBits(1);
    drain("break");
    applyStimulus(0, 9'h055, 1'b0, 2'b11);
    drain("after break 55");

    $display("[TB] two stop bits");
    applyStimulus(2, 9'h05A, 1'b0, 2'b01);
    drain("second stop low");
    applyStimulus(2, 9'h02B, 1'b0, 2'b10);
    drain("first stop low");
    applyStimulus(2, 9'($urandom_range(1, 127)), 1'b0, 2'b11);
    drain("7N2 good");

    $display("[TB] reset mid-frame");
    setLine(2, 1'b0);
    holdBits(1);
    setLine(2, 1'b1);
    holdBits(1);
    setLine(2, 1'b0);
    holdBits(1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset outputs", currentRec(2), 0);
    checkOutput("midreset busy", busy_c, 0);
    checkOutput("midreset dv", dv_c, 0);
    setLine(2, 1'b1);
    rst_n = 1'b1;
    holdBits(14);
    drain("midreset no pulse");

    $display("[TB] random frames");
    randomFrames(0, 12, "random A");
    randomFrames(1, 12, "random B");
    randomFrames(2, 12, "random C");
    tick_div = 3;
    randomFrames(0, 6, "random A slow tick");
    tick_div = 1;

    checkOutput("dv double pulse", dv_double, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
